// File: rtl/cpu_pkg.sv
// Shared constants and encodings for the 16-bit pipelined CPU.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package cpu_pkg;

  // Default field widths; pipeline registers may override them per instance.
  localparam int DEF_PC_WIDTH      = 12;
  localparam int DEF_DATA_WIDTH    = 16;
  localparam int DEF_REGADDR_WIDTH = 3;

  // ALU operation class handed from decode to EX.
  localparam int ALU_OP_WIDTH = 2;

  typedef enum logic [ALU_OP_WIDTH-1:0] {
    ALU_OP_ADD   = 2'b00,  // address generation for loads/stores
    ALU_OP_SUB   = 2'b01,  // branch compare
    ALU_OP_FUNCT = 2'b10,  // R-type, operation taken from funct field
    ALU_OP_LOGIC = 2'b11   // immediate logical ops
  } alu_op_e;

endpackage

// File: rtl/pipe_reg.sv
// Generic pipeline register with synchronous reset and synchronous clear (bubble).
// Latency: one cycle, d captured on every rising edge unless reset or clear is high.
// Backpressure: none; no enable, the register loads every cycle.
module pipe_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Reset wins over clear; both load an all-zero word, otherwise capture d.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (clear) begin
      q <= '0;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/id_ex.sv
// ID/EX pipeline register: carries decoded control, PC, operands, immediate and register addresses into EX.
// Latency: one cycle; all outputs come straight from flops, flush inserts an all-zero bubble.
// Backpressure: none; no stall input, a new instruction is captured on every non-reset, non-flush edge.
module id_ex
  import cpu_pkg::*;
#(
  parameter int PC_WIDTH      = DEF_PC_WIDTH,
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int REGADDR_WIDTH = DEF_REGADDR_WIDTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     id_reg_write,
  input  logic                     id_mem_read,
  input  logic                     id_mem_write,
  input  logic [ALU_OP_WIDTH-1:0]  id_alu_op,
  input  logic                     id_alu_src,
  input  logic                     id_branch,
  input  logic [PC_WIDTH-1:0]      id_pc,
  input  logic [DATA_WIDTH-1:0]    id_read_data1,
  input  logic [DATA_WIDTH-1:0]    id_read_data2,
  input  logic [DATA_WIDTH-1:0]    id_imm,
  input  logic [REGADDR_WIDTH-1:0] id_rs,
  input  logic [REGADDR_WIDTH-1:0] id_rt,
  input  logic [REGADDR_WIDTH-1:0] id_rd,
  output logic                     ex_reg_write,
  output logic                     ex_mem_read,
  output logic                     ex_mem_write,
  output logic [ALU_OP_WIDTH-1:0]  ex_alu_op,
  output logic                     ex_alu_src,
  output logic                     ex_branch,
  output logic [PC_WIDTH-1:0]      ex_pc,
  output logic [DATA_WIDTH-1:0]    ex_read_data1,
  output logic [DATA_WIDTH-1:0]    ex_read_data2,
  output logic [DATA_WIDTH-1:0]    ex_imm,
  output logic [REGADDR_WIDTH-1:0] ex_rs,
  output logic [REGADDR_WIDTH-1:0] ex_rt,
  output logic [REGADDR_WIDTH-1:0] ex_rd
);

  // Five single-bit controls plus the ALU op, then the datapath fields.
  localparam int CTRL_WIDTH   = 5 + ALU_OP_WIDTH;
  localparam int BUNDLE_WIDTH = CTRL_WIDTH + PC_WIDTH + 3 * DATA_WIDTH + 3 * REGADDR_WIDTH;

  logic [BUNDLE_WIDTH-1:0] id_bundle;
  logic [BUNDLE_WIDTH-1:0] ex_bundle;

  // Flatten the stage into one word so a single register covers every field; the
  // all-zero bubble then clears control and data together.
  assign id_bundle = {id_reg_write, id_mem_read, id_mem_write, id_alu_op,
                      id_alu_src, id_branch, id_pc,
                      id_read_data1, id_read_data2, id_imm,
                      id_rs, id_rt, id_rd};

  pipe_reg #(
    .WIDTH (BUNDLE_WIDTH)
  ) u_stage_reg (
    .clk   (clk),
    .reset (reset),
    .clear (flush),
    .d     (id_bundle),
    .q     (ex_bundle)
  );

  // Unpack in the same order the bundle was built.
  assign {ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_op,
          ex_alu_src, ex_branch, ex_pc,
          ex_read_data1, ex_read_data2, ex_imm,
          ex_rs, ex_rt, ex_rd} = ex_bundle;

endmodule

// File: tb/tb_id_ex.sv
// Self-checking bench for id_ex: directed plan followed by randomized traffic.
// Latency: expects every captured instruction one edge after it is driven.
// Backpressure: none modelled; the bench drives a new instruction every cycle.
module tb_id_ex;

  // One decoded instruction as the bench sees it.
  typedef struct packed {
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  alu_op;
    logic        alu_src;
    logic        branch;
    logic [11:0] pc;
    logic [15:0] rd1;
    logic [15:0] rd2;
    logic [15:0] imm;
    logic [2:0]  rs;
    logic [2:0]  rt;
    logic [2:0]  rd;
  } instr_t;

  localparam int SW = $bits(instr_t);

  logic   clk;
  logic   reset;
  logic   flush;
  instr_t din;

  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src, ex_branch;
  logic [1:0]  ex_alu_op;
  logic [11:0] ex_pc;
  logic [15:0] ex_read_data1, ex_read_data2, ex_imm;
  logic [2:0]  ex_rs, ex_rt, ex_rd;

  // Reference: the instruction EX should currently be holding.
  instr_t exp_q;

  int    n_cmp;
  int    n_err;
  string phase;

  id_ex dut (
    .clk           (clk),
    .reset         (reset),
    .flush         (flush),
    .id_reg_write  (din.reg_write),
    .id_mem_read   (din.mem_read),
    .id_mem_write  (din.mem_write),
    .id_alu_op     (din.alu_op),
    .id_alu_src    (din.alu_src),
    .id_branch     (din.branch),
    .id_pc         (din.pc),
    .id_read_data1 (din.rd1),
    .id_read_data2 (din.rd2),
    .id_imm        (din.imm),
    .id_rs         (din.rs),
    .id_rt         (din.rt),
    .id_rd         (din.rd),
    .ex_reg_write  (ex_reg_write),
    .ex_mem_read   (ex_mem_read),
    .ex_mem_write  (ex_mem_write),
    .ex_alu_op     (ex_alu_op),
    .ex_alu_src    (ex_alu_src),
    .ex_branch     (ex_branch),
    .ex_pc         (ex_pc),
    .ex_read_data1 (ex_read_data1),
    .ex_read_data2 (ex_read_data2),
    .ex_imm        (ex_imm),
    .ex_rs         (ex_rs),
    .ex_rt         (ex_rt),
    .ex_rd         (ex_rd)
  );

  // 10 ns clock, rising edges at 5, 15, 25 ns ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s/%s: got %h expected %h at %0t", phase, tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("reg_write", 64'(ex_reg_write),  64'(exp_q.reg_write));
    chk("mem_read",  64'(ex_mem_read),   64'(exp_q.mem_read));
    chk("mem_write", 64'(ex_mem_write),  64'(exp_q.mem_write));
    chk("alu_op",    64'(ex_alu_op),     64'(exp_q.alu_op));
    chk("alu_src",   64'(ex_alu_src),    64'(exp_q.alu_src));
    chk("branch",    64'(ex_branch),     64'(exp_q.branch));
    chk("pc",        64'(ex_pc),         64'(exp_q.pc));
    chk("rd1",       64'(ex_read_data1), 64'(exp_q.rd1));
    chk("rd2",       64'(ex_read_data2), 64'(exp_q.rd2));
    chk("imm",       64'(ex_imm),        64'(exp_q.imm));
    chk("rs",        64'(ex_rs),         64'(exp_q.rs));
    chk("rt",        64'(ex_rt),         64'(exp_q.rt));
    chk("rd",        64'(ex_rd),         64'(exp_q.rd));
  endtask

  // Drive one cycle from a falling edge, let the rising edge act, then check on
  // the next falling edge. A reset or flush edge leaves an empty EX slot.
  task automatic step(input instr_t v, input logic r, input logic f);
    din   = v;
    reset = r;
    flush = f;
    @(posedge clk);
    exp_q = (r || f) ? instr_t'('0) : v;
    @(negedge clk);
    check_all();
  endtask

  function automatic instr_t rand_instr();
    logic [95:0] raw;
    raw = {$urandom, $urandom, $urandom};
    return instr_t'(raw[SW-1:0]);
  endfunction

  instr_t cap_v;
  instr_t alt_v;
  instr_t ones_v;

  initial begin
    n_cmp = 0;
    n_err = 0;
    din   = '0;
    reset = 1'b1;
    flush = 1'b0;
    exp_q = '0;

    // Reset edge at 5 ns with all inputs low.
    phase = "reset";
    @(posedge clk);
    @(negedge clk);
    check_all();

    // Reset drops at 10 ns; idle edge at 15 ns captures zeros.
    phase = "idle";
    step('0, 1'b0, 1'b0);

    // Capture driven at 20 ns, edge at 25 ns, checked at 30 ns.
    phase = "capture";
    cap_v = '{reg_write: 1'b1, mem_read: 1'b1, mem_write: 1'b0, alu_op: 2'b10,
              alu_src: 1'b1, branch: 1'b1, pc: 12'hABC, rd1: 16'hAAAA,
              rd2: 16'hBBBB, imm: 16'h1234, rs: 3'b001, rt: 3'b010, rd: 3'b011};
    step(cap_v, 1'b0, 1'b0);

    // Inputs change between edges; EX must not move until the next edge.
    phase = "hold";
    alt_v = '{reg_write: 1'b0, mem_read: 1'b0, mem_write: 1'b1, alu_op: 2'b01,
              alu_src: 1'b0, branch: 1'b0, pc: 12'h123, rd1: 16'h5555,
              rd2: 16'h6666, imm: 16'hFEDC, rs: 3'b110, rt: 3'b101, rd: 3'b100};
    din = alt_v;
    #2;
    check_all();
    phase = "update";
    step(alt_v, 1'b0, 1'b0);

    // Flush with fresh nonzero inputs yields a bubble; next edge resumes capture.
    phase = "flush";
    step(cap_v, 1'b0, 1'b1);
    phase = "post_flush";
    step(cap_v, 1'b0, 1'b0);

    // Reset and flush together, then reset alone mid-stream.
    phase = "rst_and_flush";
    step(alt_v, 1'b1, 1'b1);
    phase = "reload";
    step(alt_v, 1'b0, 1'b0);
    phase = "rst_mid";
    step(cap_v, 1'b1, 1'b0);

    // All-ones: no truncation on any field.
    phase = "all_ones";
    ones_v = '1;
    step(ones_v, 1'b0, 1'b0);

    // Walking one across the whole stage: no bleed between fields.
    phase = "walk1";
    for (int b = 0; b < SW; b++) begin
      logic [SW-1:0] w;
      w    = '0;
      w[b] = 1'b1;
      step(instr_t'(w), 1'b0, 1'b0);
    end

    // Random traffic with occasional reset and flush.
    phase = "random";
    for (int i = 0; i < 400; i++) begin
      logic r;
      logic f;
      r = ($urandom_range(0, 15) == 0);
      f = ($urandom_range(0, 7) == 0);
      step(rand_instr(), r, f);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
